sel_upd: RTL
============

SEL_UPD -- requirements
Module: sel_upd

Interface
REQ-001 Parameter DEPTH, default 8, number of in-flight branch records held; power of two, 2..32.
REQ-002 Parameter AW, default 10, selection table address width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pr_valid  input  1  prediction record offered this cycle.
REQ-006 pr_addr  input  AW  selection table index used at predict time.
REQ-007 pr_cnt  input  2  selection counter value read at predict time.
REQ-008 pr_loc  input  1  local predictor direction (1 = taken).
REQ-009 pr_glb  input  1  global predictor direction (1 = taken).
REQ-010 pr_ready  output  1  record slot free; equals not-full, from registered state only.
REQ-011 res_valid  input  1  oldest in-flight branch resolved this cycle.
REQ-012 res_taken  input  1  actual direction of resolved branch.
REQ-013 flush  input  1  discard all in-flight records.
REQ-014 up_en  output  1  selection table write strobe.
REQ-015 up_addr  output  AW  selection table write index.
REQ-016 up_data  output  2  selection table write value.
REQ-017 occ  output  log2(DEPTH)+1  current record count.
REQ-018 orphan  output  1  sticky: res_valid seen while empty.

Function
REQ-019 Records SHALL be stored in program order in a DEPTH-entry FIFO; push when pr_valid and pr_ready.
REQ-020 pr_valid while full SHALL be dropped with no state change.
REQ-021 res_valid SHALL pop the oldest record; when empty it SHALL be ignored and set orphan.
REQ-022 Push and pop in the same cycle SHALL both occur, including at full (pop frees slot, pr_ready stays as registered) and empty (pop ignored, push stored).
REQ-023 On pop: loc_ok = (pr_loc == res_taken), glb_ok = (pr_glb == res_taken).
REQ-024 loc_ok == glb_ok SHALL produce no write.
REQ-025 glb_ok and not loc_ok SHALL compute new = cnt+1 saturating at 3; loc_ok and not glb_ok SHALL compute new = cnt-1 saturating at 0.
REQ-026 Write SHALL be suppressed when new equals stored cnt (saturated).
REQ-027 up_en, up_addr, up_data SHALL be registered, asserted exactly one cycle, the cycle after the accepting res_valid edge; latency 1.
REQ-028 up_addr/up_data SHALL hold last value when up_en is low.
REQ-029 flush SHALL empty the FIFO; pr_valid and res_valid in the flush cycle SHALL be ignored; a write already registered SHALL still issue.
REQ-030 occ SHALL track entries exactly; pointers wrap modulo DEPTH.

Reset
REQ-031 reset SHALL clear FIFO, occ=0, pr_ready=1, up_en=0, up_addr=0, up_data=0, orphan=0.
REQ-032 reset SHALL dominate flush, pr_valid and res_valid in the same cycle; reset mid-stream discards all records.
REQ-033 orphan SHALL clear only on reset.

Configuration
REQ-034 Macro SEL_UPD_FWD_EN defined: on each issued write, remaining FIFO records with matching addr SHALL take cnt = new; a same-cycle push with matching addr SHALL store new instead of pr_cnt.
REQ-035 SEL_UPD_FWD_EN undefined: records keep pr_cnt as captured; no forwarding logic present.

Verification
REQ-036 Push {addr=5,cnt=1,loc=0,glb=1}, resolve taken -> next cycle up_en=1, up_addr=5, up_data=2.
REQ-037 Push {addr=7,cnt=0,loc=1,glb=0}, resolve taken -> up_en stays 0 (saturated); {addr=7,cnt=2,loc=1,glb=1} resolve 0 -> up_en 0.
REQ-038 Push 8 records -> pr_ready=0, occ=8; 9th dropped; push+resolve same cycle -> occ=8, oldest written.
REQ-039 res_valid with occ=0 -> no write, orphan=1 until reset; flush with occ=3 -> occ=0, next res_valid sets orphan.
REQ-040 Two records addr=3,cnt=1, both glb-correct: FWD_EN -> writes 2 then 3; without -> writes 2 then 2.
REQ-041 Reset asserted with occ=4 and res_valid high -> no up_en next cycle, occ=0, pr_ready=1.

Source files
------------

// File: rtl/sel_upd.sv
// Selection-counter update queue: holds predict-time records in program order and turns
// resolved outcomes into selection table writes. Optional forwarding: SEL_UPD_FWD_EN.
module sel_upd #(
  parameter int DEPTH = 8,
  parameter int AW    = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pr_valid,
  input  logic [AW-1:0]            pr_addr,
  input  logic [1:0]               pr_cnt,
  input  logic                     pr_loc,
  input  logic                     pr_glb,
  output logic                     pr_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic                     flush,
  output logic                     up_en,
  output logic [AW-1:0]            up_addr,
  output logic [1:0]               up_data,
  output logic [$clog2(DEPTH):0]   occ,
  output logic                     orphan
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic inc);
    if (inc) return (c == 2'd3) ? c : c + 2'd1;
    else     return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  logic [AW-1:0] mem_addr [DEPTH];
  logic [1:0]    mem_cnt  [DEPTH];
  logic          mem_loc  [DEPTH];
  logic          mem_glb  [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [OW-1:0] occ_q;
  logic          orphan_q;

  logic          vld_p1;
  logic [AW-1:0] addr_p1;
  logic [1:0]    data_p1;

  logic          full_p0, empty_p0, pop_p0, push_p0, wr_p0;
  logic          loc_ok_p0, glb_ok_p0;
  logic [AW-1:0] head_addr_p0;
  logic [1:0]    head_cnt_p0, new_cnt_p0, push_cnt_p0;

  // Stage p0: FIFO head evaluation and push/pop decisions
  always_comb begin
    full_p0      = (occ_q == OW'(DEPTH));
    empty_p0     = (occ_q == '0);
    pop_p0       = res_valid && !flush && !empty_p0;
    // A pop at full frees the slot this same cycle, so a push may ride along
    push_p0      = pr_valid && !flush && (!full_p0 || pop_p0);
    head_addr_p0 = mem_addr[rd_ptr];
    head_cnt_p0  = mem_cnt[rd_ptr];
    loc_ok_p0    = (mem_loc[rd_ptr] == res_taken);
    glb_ok_p0    = (mem_glb[rd_ptr] == res_taken);
    new_cnt_p0   = sat_step(head_cnt_p0, glb_ok_p0);
    wr_p0        = pop_p0 && (loc_ok_p0 != glb_ok_p0) && (new_cnt_p0 != head_cnt_p0);
    push_cnt_p0  = pr_cnt;
`ifdef SEL_UPD_FWD_EN
    if (wr_p0 && (pr_addr == head_addr_p0)) push_cnt_p0 = new_cnt_p0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ_q    <= '0;
      orphan_q <= 1'b0;
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      data_p1  <= '0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        occ_q  <= '0;
      end else begin
        if (push_p0) wr_ptr <= wr_ptr + 1'b1;
        if (pop_p0)  rd_ptr <= rd_ptr + 1'b1;
        case ({push_p0, pop_p0})
          2'b10:   occ_q <= occ_q + 1'b1;
          2'b01:   occ_q <= occ_q - 1'b1;
          default: occ_q <= occ_q;
        endcase
      end
      if (res_valid && !flush && empty_p0) orphan_q <= 1'b1;
      vld_p1 <= wr_p0;
      if (wr_p0) begin
        addr_p1 <= head_addr_p0;
        data_p1 <= new_cnt_p0;
      end
    end
  end

  // Record storage is data-only; validity comes from the pointers
  always_ff @(posedge clk) begin
`ifdef SEL_UPD_FWD_EN
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_p0 && (mem_addr[i] == head_addr_p0)) mem_cnt[i] <= new_cnt_p0;
    end
`endif
    if (push_p0) begin
      mem_addr[wr_ptr] <= pr_addr;
      mem_cnt[wr_ptr]  <= push_cnt_p0;
      mem_loc[wr_ptr]  <= pr_loc;
      mem_glb[wr_ptr]  <= pr_glb;
    end
  end

  // Stage p1: registered write port
  assign up_en    = vld_p1;
  assign up_addr  = addr_p1;
  assign up_data  = data_p1;
  assign occ      = occ_q;
  assign pr_ready = (occ_q != OW'(DEPTH));
  assign orphan   = orphan_q;

endmodule
